sram_arbiter: RTL and testbench

//  Shares the single sram_ctrl port between VGA scan-out reads and two pixel writers (frame_drawer, battle_drawer).

---
 rtl/sram_arb_pkg.sv | 15 +
 rtl/sram_arb_wsel.sv | 35 +++
 rtl/sram_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } arb_state_t;

  // sram_ctrl direction encoding
  localparam logic SRAM_RD = 1'b1;
  localparam logic SRAM_WR = 1'b0;

endpackage

// File: rtl/sram_arb_wsel.sv
// Two-way writer select for the SRAM arbiter.
// Build option SRAM_ARB_RR_EN: round-robin between the two writers using an
// rr_ptr register; without it requester 0 has fixed priority and the module
// is purely combinational.
module sram_arb_wsel (
`ifdef SRAM_ARB_RR_EN
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       take,      // a write grant is being issued this cycle
`endif
  input  logic [1:0] wr_req,
  output logic       sel        // index of the winning requester
);
  import sram_arb_pkg::*;

`ifdef SRAM_ARB_RR_EN
  logic rr_ptr;

  // Pick the pointed-to side on contention, otherwise whoever is asking
  always_comb begin
    sel = ~wr_req[0] & wr_req[1];
    if (&wr_req) sel = rr_ptr;
  end

  // After every grant, point at the side that did not win
  always_ff @(posedge Clk) begin
    if (!reset_n)  rr_ptr <= 1'b0;
    else if (take) rr_ptr <= ~sel;
  end
`else
  // Fixed priority: requester 0 wins whenever it is asking
  assign sel = ~wr_req[0] & wr_req[1];
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single sram_ctrl port between VGA scan-out reads (active video,
// one read per pixel tick) and two pixel writers (granted during blanking).
// Reads always outrank writes; at most one SRAM op is outstanding.
// Build option SRAM_ARB_RR_EN selects round-robin writer arbitration
// (default: fixed priority, frame_drawer first).
module sram_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              pix_tick,
  input  logic              vga_blank_n,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  output logic [DATA_W-1:0] pixel_data,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_gnt,
  output logic [1:0]        wr_done,
  output logic              underrun,
  output logic              ctrl_start_n,
  output logic              ctrl_rw,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_wdata,
  input  logic              ctrl_ready,
  input  logic [DATA_W-1:0] ctrl_rdata
);
  import sram_arb_pkg::*;

  arb_state_t        state;
  logic              lo_wait;   // WAIT_LO already spent one cycle with ready high
  logic              op_sel;    // requester owning the write in flight
  logic              sel;
  logic              rd_go, wr_go;
  logic [ADDR_W-1:0] rd_addr;

  // Full-width product: 479*640+639 fits in 20 bits, so nothing is lost
  assign rd_addr = ADDR_W'(draw_y) * ADDR_W'(H_ACTIVE) + ADDR_W'(draw_x);
  assign rd_go   = vga_blank_n & pix_tick & ctrl_ready;
  assign wr_go   = ~vga_blank_n & (|wr_req) & ctrl_ready;

  sram_arb_wsel u_wsel (
`ifdef SRAM_ARB_RR_EN
    .Clk     (Clk),
    .reset_n (reset_n),
    .take    ((state == IDLE) && wr_go),
`endif
    .wr_req  (wr_req),
    .sel     (sel)
  );

  // Arbitration FSM and registered sram_ctrl / requester outputs
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      lo_wait      <= 1'b0;
      op_sel       <= 1'b0;
      ctrl_start_n <= 1'b1;
      ctrl_rw      <= SRAM_RD;
      ctrl_addr    <= '0;
      ctrl_wdata   <= '0;
      pixel_data   <= '0;
      wr_gnt       <= '0;
      wr_done      <= '0;
      underrun     <= 1'b0;
    end else begin
      ctrl_start_n <= 1'b1;
      wr_gnt       <= '0;
      wr_done      <= '0;
      // A visible pixel arrived while the port was still busy: pixel_data
      // keeps its old value and the miss is remembered until reset
      if (vga_blank_n && pix_tick && state != IDLE) underrun <= 1'b1;
      case (state)
        IDLE: begin
          lo_wait <= 1'b0;
          if (rd_go) begin
            state        <= ISSUE;
            ctrl_start_n <= 1'b0;
            ctrl_rw      <= SRAM_RD;
            ctrl_addr    <= rd_addr;
          end else if (wr_go) begin
            state        <= ISSUE;
            ctrl_start_n <= 1'b0;
            ctrl_rw      <= SRAM_WR;
            ctrl_addr    <= sel ? wr_addr1 : wr_addr0;
            ctrl_wdata   <= sel ? wr_data1 : wr_data0;
            op_sel       <= sel;
            wr_gnt       <= sel ? 2'b10 : 2'b01;
          end
        end
        ISSUE: state <= WAIT_LO;
        WAIT_LO: begin
          if (!ctrl_ready) begin
            state <= WAIT_HI;
          end else if (lo_wait) begin
            // ctrl never went busy: treat the op as already complete
            state <= IDLE;
            if (ctrl_rw == SRAM_RD) pixel_data <= ctrl_rdata;
            else                    wr_done    <= op_sel ? 2'b10 : 2'b01;
          end else begin
            lo_wait <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (ctrl_ready) begin
            state <= IDLE;
            if (ctrl_rw == SRAM_RD) pixel_data <= ctrl_rdata;
            else                    wr_done    <= op_sel ? 2'b10 : 2'b01;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized scoreboard bench for sram_arbiter with a behavioural sram_ctrl.
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          reset_n, pix_tick, vga_blank_n;
  logic [9:0]    draw_x, draw_y;
  logic [DW-1:0] pixel_data;
  logic [1:0]    wr_req;
  logic [AW-1:0] wr_addr0, wr_addr1;
  logic [DW-1:0] wr_data0, wr_data1;
  logic [1:0]    wr_gnt, wr_done;
  logic          underrun, ctrl_start_n, ctrl_rw;
  logic [AW-1:0] ctrl_addr;
  logic [DW-1:0] ctrl_wdata;
  logic          ctrl_ready = 1'b1;
  logic [DW-1:0] ctrl_rdata = '0;

  always #5 Clk = ~Clk;

  sram_arbiter dut (
    .Clk(Clk), .reset_n(reset_n), .pix_tick(pix_tick), .vga_blank_n(vga_blank_n),
    .draw_x(draw_x), .draw_y(draw_y), .pixel_data(pixel_data),
    .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt(wr_gnt), .wr_done(wr_done),
    .underrun(underrun), .ctrl_start_n(ctrl_start_n), .ctrl_rw(ctrl_rw),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_ready(ctrl_ready),
    .ctrl_rdata(ctrl_rdata)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wd_t;
  typedef struct { int id; logic [AW-1:0] addr; logic [DW-1:0] data; } wx_t;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memories: SRAM contents and reference view ----------------
  logic [DW-1:0] smem [int];
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    m = a * 20'd13;
    return m[DW-1:0] ^ 16'h5A5A;
  endfunction
  function automatic logic [DW-1:0] smem_rd(input logic [AW-1:0] a);
    return smem.exists(int'(a)) ? smem[int'(a)] : init_val(a);
  endfunction
  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  // ---------------- sram_ctrl model: busy model_n cycles after start ----------------
  int            model_n  = 1;
  int            busy_cnt = 0;
  logic          op_rw    = 1'b1;
  logic [AW-1:0] op_addr  = '0;
  logic [DW-1:0] op_wdata = '0;

  always @(posedge Clk) begin
    if (!ctrl_start_n) begin
      ctrl_ready <= 1'b0;
      busy_cnt   <= model_n;
      op_rw      <= ctrl_rw;
      op_addr    <= ctrl_addr;
      op_wdata   <= ctrl_wdata;
    end else if (!ctrl_ready) begin
      if (busy_cnt <= 1) begin
        ctrl_ready <= 1'b1;
        if (op_rw) ctrl_rdata <= smem_rd(op_addr);
        else       smem[int'(op_addr)] = op_wdata;
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard queues ----------------
  wd_t rq[$];          // expected reads: address and returned word
  wx_t wq[$];          // expected grants in order
  wx_t dq[$];          // granted writes awaiting completion
  wd_t wp0[$], wp1[$]; // per-writer pending payloads (driver side)
  int  ref_ptr = 0;    // reference round-robin preference

  // Writers: hold request with the head payload, advance after each grant
  initial begin
    wr_req = '0; wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    forever begin
      @(negedge Clk);
      if (wr_gnt[0] && wp0.size() > 0) void'(wp0.pop_front());
      if (wr_gnt[1] && wp1.size() > 0) void'(wp1.pop_front());
      wr_req[0] = (wp0.size() > 0);
      wr_req[1] = (wp1.size() > 0);
      if (wp0.size() > 0) begin wr_addr0 = wp0[0].addr; wr_data0 = wp0[0].data; end
      if (wp1.size() > 0) begin wr_addr1 = wp1[0].addr; wr_data1 = wp1[0].data; end
    end
  end

  // ---------------- monitor ----------------
  bit            mon_en = 1'b1, rd_track = 1'b1, rd_wait = 1'b0, pix_due = 1'b0;
  bit            prev_ready = 1'b1, prev_start_low = 1'b0;
  logic [DW-1:0] exp_pix = '0;

  initial begin
    wd_t r;
    wx_t w;
    forever begin
      @(negedge Clk);
      if (mon_en && reset_n) begin
        if (pix_due) begin chk("pixel_data", pixel_data, exp_pix); pix_due = 1'b0; end
        if (rd_wait && !prev_ready && ctrl_ready) begin rd_wait = 1'b0; pix_due = 1'b1; end
        if (!ctrl_start_n) begin
          chk("start_n_one_cycle", prev_start_low, 0);
          if (ctrl_rw && rd_track) begin
            if (rq.size() == 0) chk("unexpected_read", ctrl_addr, 0);
            else begin
              r = rq.pop_front();
              chk("rd_addr", ctrl_addr, r.addr);
              exp_pix = r.data;
              rd_wait = 1'b1;
            end
          end
        end
        if (wr_gnt != 0 || wr_done != 0) chk("gnt_done_overlap", (wr_gnt != 0) && (wr_done != 0), 0);
        if (wr_gnt != 0) begin
          if (wq.size() == 0) chk("unexpected_gnt", wr_gnt, 0);
          else begin
            w = wq.pop_front();
            chk("gnt_id", wr_gnt, 32'd1 << w.id);
            chk("wr_rw", ctrl_rw, 0);
            chk("wr_start", ctrl_start_n, 0);
            chk("wr_addr", ctrl_addr, w.addr);
            chk("wr_data", ctrl_wdata, w.data);
            dq.push_back(w);
          end
        end
        if (wr_done != 0) begin
          if (dq.size() == 0) chk("unexpected_done", wr_done, 0);
          else begin
            w = dq.pop_front();
            chk("done_id", wr_done, 32'd1 << w.id);
            chk("sram_content", smem_rd(w.addr), w.data);
          end
        end
      end
      prev_ready     = ctrl_ready;
      prev_start_low = !ctrl_start_n;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_drain();
    int t = 0;
    while ((rq.size() > 0 || wq.size() > 0 || dq.size() > 0 || wp0.size() > 0 ||
            wp1.size() > 0 || rd_wait || pix_due || !ctrl_ready || !ctrl_start_n) && t < 3000) begin
      @(negedge Clk);
      t++;
    end
    chk("drain_timeout", t >= 3000, 0);
    repeat (2) @(negedge Clk);
  endtask

  task automatic do_read(input logic [9:0] x, input logic [9:0] y);
    wd_t r;
    draw_x = x; draw_y = y; vga_blank_n = 1'b1; pix_tick = 1'b1;
    r.addr = AW'(y) * 20'd640 + AW'(x);
    r.data = ref_rd(r.addr);
    if (rd_track) rq.push_back(r);
    @(negedge Clk);
    pix_tick = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  task automatic rand_pl(input int n, output wd_t q[$]);
    wd_t p;
    q.delete();
    repeat (n) begin
      p.addr = AW'($urandom_range(0, 63));
      p.data = DW'($urandom);
      q.push_back(p);
    end
  endtask

  // Reference arbitration: predict grant order from the arbitration rule
  task automatic plan(input wd_t p0[$], input wd_t p1[$]);
    int  i0 = 0, i1 = 0, sel;
    wx_t w;
    while (i0 < p0.size() || i1 < p1.size()) begin
      if (i0 < p0.size() && i1 < p1.size()) begin
`ifdef SRAM_ARB_RR_EN
        sel = ref_ptr;
`else
        sel = 0;
`endif
      end else begin
        sel = (i0 < p0.size()) ? 0 : 1;
      end
      w.id = sel;
      if (sel == 0) begin w.addr = p0[i0].addr; w.data = p0[i0].data; i0++; end
      else          begin w.addr = p1[i1].addr; w.data = p1[i1].data; i1++; end
      wq.push_back(w);
      ref_mem[int'(w.addr)] = w.data;
      ref_ptr = (sel == 0) ? 1 : 0;
    end
    wp0 = p0;
    wp1 = p1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start_n"}, ctrl_start_n, 1);
    chk({tag, "_rw"},      ctrl_rw, 1);
    chk({tag, "_addr"},    ctrl_addr, 0);
    chk({tag, "_wdata"},   ctrl_wdata, 0);
    chk({tag, "_pixel"},   pixel_data, 0);
    chk({tag, "_gnt"},     wr_gnt, 0);
    chk({tag, "_done"},    wr_done, 0);
    chk({tag, "_underrun"}, underrun, 0);
  endtask

  // ---------------- main sequence ----------------
  wd_t pa[$], pb[$];
  wd_t one;
  int  cnt, lat;

  initial begin
    reset_n = 1'b0; pix_tick = 1'b0; vga_blank_n = 1'b0; draw_x = '0; draw_y = '0;
    repeat (3) @(negedge Clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge Clk);

    // Scan-out reads
    do_read(10'd5, 10'd2);
    wait_drain();
    repeat (12) do_read(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)));
    do_read(10'd639, 10'd479);
    wait_drain();

    // Directed write during blanking, then read it back through scan-out
    vga_blank_n = 1'b0;
    pa.delete(); pb.delete();
    one.addr = 20'h00100; one.data = 16'hBEEF;
    pa.push_back(one);
    plan(pa, pb);
    wait_drain();
    do_read(10'd256, 10'd0);
    wait_drain();

    // Writes held off during active video, granted promptly once blanking starts
    vga_blank_n = 1'b1;
    rand_pl(1, pa); pb.delete();
    plan(pa, pb);
    cnt = 0;
    repeat (100) begin @(negedge Clk); if (wr_gnt != 0) cnt++; end
    chk("no_gnt_in_active", cnt, 0);
    vga_blank_n = 1'b0;
    lat = 0;
    while (wr_gnt == 0 && lat < 10) begin @(negedge Clk); lat++; end
    chk("gnt_within_3", lat <= 3, 1);
    wait_drain();

    // Contention: both writers asking
    rand_pl(4, pa); rand_pl(2, pb);
    plan(pa, pb);
    wait_drain();
    repeat (8) begin
      rand_pl($urandom_range(0, 3), pa);
      rand_pl($urandom_range(0, 3), pb);
      plan(pa, pb);
      wait_drain();
    end

    // Scan-out over the written region
    repeat (10) do_read(10'($urandom_range(0, 63)), 10'd0);
    wait_drain();

    // Slow controller: pixel ticks every 2 cycles must miss reads
    chk("underrun_idle", underrun, 0);
    model_n = 4; rd_track = 1'b0; vga_blank_n = 1'b1;
    repeat (10) begin
      pix_tick = 1'b1; @(negedge Clk);
      pix_tick = 1'b0; @(negedge Clk);
    end
    vga_blank_n = 1'b0;
    wait_drain();
    chk("underrun_set", underrun, 1);
    repeat (20) @(negedge Clk);
    chk("underrun_sticky", underrun, 1);
    reset_n = 1'b0;
    @(negedge Clk);
    chk("underrun_reset", underrun, 0);
    chk("pixel_reset", pixel_data, 0);
    reset_n = 1'b1; ref_ptr = 0; rd_track = 1'b1;
    @(negedge Clk);

    // Reset while waiting for a slow write to complete
    rand_pl(1, pa); pb.delete();
    plan(pa, pb);
    lat = 0;
    while (wr_gnt[0] == 1'b0 && lat < 20) begin @(negedge Clk); lat++; end
    chk("rst_test_gnt", wr_gnt[0], 1);
    @(negedge Clk);
    @(negedge Clk);
    mon_en = 1'b0;
    reset_n = 1'b0;
    @(negedge Clk);
    chk_reset_outputs("midop_reset");
    reset_n = 1'b1; ref_ptr = 0;
    cnt = 0;
    repeat (12) begin @(negedge Clk); if (wr_done != 0) cnt++; end
    chk("no_done_after_reset", cnt, 0);
    wq.delete(); dq.delete(); rd_wait = 1'b0; pix_due = 1'b0;
    mon_en = 1'b1; model_n = 1;
    wait_drain();

    // Normal operation resumes after reset
    repeat (6) do_read(10'($urandom_range(0, 63)), 10'd0);
    wait_drain();
    vga_blank_n = 1'b0;
    rand_pl(2, pa); rand_pl(2, pb);
    plan(pa, pb);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
